// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-stage RAM arbiter.
// Used by mem_arbiter and mem_arb_pick.
package mem_arb_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Owner of the access in flight
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Width of the starvation counter (STARVE_MAX up to 7)
    localparam int STARVE_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requesters with a
// saturating starvation counter that forces IF to win after
// STARVE_MAX consecutive D grants while if_req is pending.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   if_req_i,
    input  logic   d_req_i,
    input  logic   take_i,
    output owner_t win_o
);

    localparam logic [STARVE_W-1:0] MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;

    // D wins contention unless IF has been passed over STARVE_MAX times
    always_comb begin
        win_o = OWN_IF;
        if (d_req_i && !(if_req_i && (starve_q == MAX)))
            win_o = OWN_D;
    end

    // Count D grants that overtook a pending IF; clear otherwise
    always_comb begin
        starve_d = starve_q;
        if (take_i) begin
            if ((win_o == OWN_D) && if_req_i)
                starve_d = (starve_q == MAX) ? starve_q : starve_q + 1'b1;
            else
                starve_d = '0;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM sequencer for the multicycle CPU memory stage.
// Arbitrates IF (read-only) and D (load/store) requesters; each
// grant runs a fixed ISSUE/ACCESS/RESP schedule.
// Optional write protection below PROT_LIMIT: define MEM_ARB_WPROT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W     = 9,
    parameter int                DATA_W     = 32,
    parameter int                STARVE_MAX = 2,
    parameter logic [ADDR_W-1:0] PROT_LIMIT = 9'h080
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    state_t              state_q;
    owner_t              owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_din_q;
    logic                ram_we_q;
    logic                if_gnt_q;
    logic                d_gnt_q;
    logic                if_valid_q;
    logic                d_valid_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                busy_q;

    owner_t              win;
    logic                take;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_we;
    logic                sel_blocked;

`ifdef MEM_ARB_WPROT_EN
    logic                blocked_q;
    logic                d_err_q;
`endif

    // Upper address bits are deliberately discarded
    logic unused_addr;
    assign unused_addr = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

    assign take = (state_q == IDLE) && (if_req || d_req);

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .take_i   (take),
        .win_o    (win)
    );

    // Address/command of the winning requester
    always_comb begin
        sel_addr = if_addr[ADDR_W-1:0];
        sel_we   = 1'b0;
        if (win == OWN_D) begin
            sel_addr = d_addr[ADDR_W-1:0];
            sel_we   = d_we;
        end
    end

`ifdef MEM_ARB_WPROT_EN
    assign sel_blocked = sel_we && (sel_addr < PROT_LIMIT);
    assign d_err       = d_err_q;
`else
    logic unused_prot;
    assign unused_prot = (d_addr[ADDR_W-1:0] < PROT_LIMIT);
    assign sel_blocked = 1'b0;
    assign d_err       = 1'b0;
`endif

    // Access sequencer with registered RAM pins, strobes and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            busy_q     <= 1'b0;
`ifdef MEM_ARB_WPROT_EN
            blocked_q  <= 1'b0;
            d_err_q    <= 1'b0;
`endif
        end else begin
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
`ifdef MEM_ARB_WPROT_EN
            d_err_q    <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (take) begin
                        owner_q    <= win;
                        we_q       <= sel_we;
                        ram_addr_q <= sel_addr;
                        if (win == OWN_D)
                            ram_din_q <= d_wdata;
                        ram_we_q   <= sel_we && !sel_blocked;
                        if_gnt_q   <= (win == OWN_IF);
                        d_gnt_q    <= (win == OWN_D);
                        busy_q     <= 1'b1;
`ifdef MEM_ARB_WPROT_EN
                        blocked_q  <= sel_blocked;
`endif
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_we_q <= 1'b0;
                    state_q  <= RESP;
                end
                RESP: begin
                    if (owner_q == OWN_D) begin
                        if (!we_q)
                            d_rdata_q <= ram_dout;
                        d_valid_q <= 1'b1;
`ifdef MEM_ARB_WPROT_EN
                        d_err_q   <= blocked_q;
`endif
                    end else begin
                        if_rdata_q <= ram_dout;
                        if_valid_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ram_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign if_gnt   = if_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign if_valid = if_valid_q;
    assign d_valid  = d_valid_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_we   = ram_we_q;
    assign busy     = busy_q;

endmodule
